// File: rtl/perf_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Brief    : Shared types and helpers for the performance-counter dump block.
// Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

  // Controller states: IDLE waits for a trigger, DRAIN streams the snapshot.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } perf_state_e;

  localparam int DEF_NUM_EVENT = 8;
  localparam int DEF_CNT_WIDTH = 32;

  // Width of an event-source index; never narrower than one bit.
  function automatic int id_w(input int num_event);
    return (num_event > 1) ? $clog2(num_event) : 1;
  endfunction

  localparam int DEF_ID_W = id_w(DEF_NUM_EVENT);

  // One dump beat as seen by the log sink (default-configuration widths).
  typedef struct packed {
    logic [DEF_ID_W-1:0]      id;
    logic [DEF_CNT_WIDTH-1:0] value;
    logic                     sat;
  } perf_entry_t;

endpackage
`default_nettype wire

// File: rtl/perf_counter_sat.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_sat
// Brief    : Saturating event counter with a sticky saturation flag. A clear
//            wins over an increment, but an increment in the clear cycle is
//            kept so the counter restarts at 1 instead of losing the event.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_sat #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sat
);

  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_sat;

  // Count up to the ceiling; the flag latches once the ceiling is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clr) begin
      r_count <= inc ? C_ONE : '0;
      r_sat   <= inc && (C_ONE == C_MAX);
    end else if (inc) begin
      if (r_count != C_MAX) begin
        r_count <= r_count + C_ONE;
      end
      if (r_count >= (C_MAX - C_ONE)) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/perf_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perf_dump_ctrl
// Brief    : Per-source saturating event counters sharing one serial dump
//            port. A dump request or the interval timer snapshots every
//            counter in one cycle; the snapshot is then drained one entry per
//            accepted valid/ready beat. Triggers arriving mid-drain collapse
//            into a single pending dump started right after the last beat.
// Revision : 1.0 - initial release
// ============================================================================
module perf_dump_ctrl
  import perf_pkg::*;
#(
  parameter int NUM_EVENT     = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int INTERVAL      = 4096,
  parameter int CLEAR_ON_DUMP = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cnt_en,
  input  logic [NUM_EVENT-1:0]         event_i,
  input  logic                         dump_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_EVENT)-1:0] out_id,
  output logic [CNT_WIDTH-1:0]         out_value,
  output logic                         out_sat,
  output logic                         out_last,
  output logic                         busy
);

  localparam int             ID_W       = id_w(NUM_EVENT);
  localparam logic [ID_W-1:0] C_IDX_LAST = ID_W'(NUM_EVENT - 1);
  localparam logic [ID_W-1:0] C_IDX_ONE  = ID_W'(1);

  perf_state_e          r_state;
  perf_state_e          w_state_nxt;
  logic [ID_W-1:0]      r_idx;
  logic                 r_pending;
  logic                 w_timer_hit;
  logic                 w_trigger;
  logic                 w_take;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_clr;

  logic [CNT_WIDTH-1:0] w_live_cnt [NUM_EVENT];
  logic [NUM_EVENT-1:0] w_live_sat;
  logic [CNT_WIDTH-1:0] r_snap_val [NUM_EVENT];
  logic [NUM_EVENT-1:0] r_snap_sat;

  // --------------------------------------------------------------------------
  // Interval timer: free-running, independent of cnt_en and of the FSM.
  // --------------------------------------------------------------------------
  generate
    if (INTERVAL != 0) begin : g_timer
      localparam int              TMR_W      = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
      localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(INTERVAL - 1);
      localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);

      logic [TMR_W-1:0] r_timer;

      // Wrap to zero on the terminal count so the period is exactly INTERVAL.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_timer <= '0;
        end else if (r_timer == C_TMR_LAST) begin
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + C_TMR_ONE;
        end
      end

      assign w_timer_hit = (r_timer == C_TMR_LAST);
    end else begin : g_no_timer
      assign w_timer_hit = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Live counters. The snapshot cycle clears them when CLEAR_ON_DUMP is set;
  // an event in that same cycle lands in the new epoch, not in the snapshot.
  // --------------------------------------------------------------------------
  assign w_clr = w_take && (CLEAR_ON_DUMP != 0);

  generate
    for (genvar gi = 0; gi < NUM_EVENT; gi++) begin : g_cnt
      perf_counter_sat #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_en & event_i[gi]),
        .clr   (w_clr),
        .count (w_live_cnt[gi]),
        .sat   (w_live_sat[gi])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------
  assign w_trigger = dump_req | w_timer_hit | r_pending;
  assign w_last    = (r_idx == C_IDX_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the snapshot and beat-accept strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_take      = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Drain pointer: restarts at entry 0 on each snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else if (w_take) begin
      r_idx <= '0;
    end else if (w_accept && !w_last) begin
      r_idx <= r_idx + C_IDX_ONE;
    end
  end

  // Any number of triggers during a drain fold into one follow-up dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_pending <= 1'b0;
    end else if ((r_state == ST_DRAIN) && (dump_req || w_timer_hit)) begin
      r_pending <= 1'b1;
    end
  end

  // Snapshot captures the pre-increment live values; frozen during DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EVENT; i++) begin
        r_snap_val[i] <= '0;
      end
      r_snap_sat <= '0;
    end else if (w_take) begin
      for (int i = 0; i < NUM_EVENT; i++) begin
        r_snap_val[i] <= w_live_cnt[i];
      end
      r_snap_sat <= w_live_sat;
    end
  end

  // --------------------------------------------------------------------------
  // Output port: driven from state so reset removes out_valid immediately.
  // Payload is forced to zero outside DRAIN.
  // --------------------------------------------------------------------------
  assign out_valid = (r_state == ST_DRAIN);
  assign busy      = out_valid;
  assign out_id    = out_valid ? r_idx : '0;
  assign out_value = out_valid ? r_snap_val[r_idx] : '0;
  assign out_sat   = out_valid && r_snap_sat[r_idx];
  assign out_last  = out_valid && w_last;

endmodule
`default_nettype wire
